// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB completer memory
//
// Purpose: FSM state encoding, strobe/wait-counter widths and the data word
// type used by apb_slave_mem and apb_mem_array.
// Ports: none (package).

package apb_pkg;

  localparam int APB_STRB_W = 4;
  localparam int APB_WAIT_W = 4;

  typedef logic [31:0] apb_data_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_mem_array.sv
// rtl/apb_mem_array.sv - word storage with byte-strobe write and async read
//
// Purpose: MEM_DEPTH x 32-bit memory, cleared by reset.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_en           commit wr_data into word wr_idx this edge
//   wr_idx, wr_data word index and data for the write
//   wr_strb         per-byte write enables
//   rd_idx          combinational read index
//   rd_data         contents of word rd_idx

module apb_mem_array
  import apb_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int IDX_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  apb_data_t             wr_data,
  input  logic [APB_STRB_W-1:0] wr_strb,
  input  logic [IDX_W-1:0]      rd_idx,
  output apb_data_t             rd_data
);

  apb_data_t mem [MEM_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < APB_STRB_W; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB4 completer with memory, wait states and range error
//
// Purpose: responds to APB transfers against an internal word memory,
// inserting WAIT_STATES low-PREADY access cycles and flagging PSLVERR for
// addresses beyond MEM_DEPTH words.
// Ports:
//   PCLK, PRESET              clock, asynchronous active-high reset
//   PSEL, PENABLE, PWRITE     APB control
//   PADDR, PWDATA, PSTRB      byte address, write data, write byte enables
//   PREADY, PRDATA, PSLVERR   registered completion response

module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [APB_STRB_W-1:0] PSTRB,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-3:0] DEPTH_LIM = (ADDR_WIDTH-2)'(MEM_DEPTH);
  localparam bit ZERO_WAIT = (WAIT_STATES == 0);

  apb_state_t state, state_d;

  logic [APB_WAIT_W-1:0] cnt;
  logic [IDX_W-1:0]      idx_q;
  logic                  wr_q, err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [APB_STRB_W-1:0] strb_q;

  logic                  setup_hit, addr_err, last_wait, respond;
  logic                  resp_err, resp_wr, mem_we;
  logic [IDX_W-1:0]      addr_idx, rd_idx;
  apb_data_t             rd_data;
  logic                  pready_d, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_d;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^PADDR[1:0];

  assign setup_hit = (state == IDLE) && PSEL && !PENABLE;
  assign addr_err  = (PADDR[ADDR_WIDTH-1:2] >= DEPTH_LIM);
  assign addr_idx  = PADDR[IDX_W+1:2];
  // The counter holds the waits still owed; the response is registered
  // during the last wait so PREADY is high in access cycle WAIT_STATES+1.
  assign last_wait = (cnt == APB_WAIT_W'(1));

  // With zero waits the response is registered at the setup edge, before
  // the request fields have been latched, so take them straight off the bus.
  assign respond  = (setup_hit && ZERO_WAIT) ||
                    ((state == ACCESS) && PSEL && last_wait);
  assign resp_err = setup_hit ? addr_err : err_q;
  assign resp_wr  = setup_hit ? PWRITE   : wr_q;
  assign rd_idx   = setup_hit ? addr_idx : idx_q;

  // Memory commits at the end of the completion cycle only.
  assign mem_we = (state == DONE) && wr_q && !err_q;

  apb_mem_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk     (PCLK),
    .rst     (PRESET),
    .wr_en   (mem_we),
    .wr_idx  (idx_q),
    .wr_data (wdata_q),
    .wr_strb (strb_q),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (setup_hit) state_d = ZERO_WAIT ? DONE : ACCESS;
      ACCESS:  begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (last_wait) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response values are zero in every cycle except the one raising PREADY,
  // which also clears them at the edge ending the completion cycle.
  always_comb begin
    pready_d  = respond;
    pslverr_d = respond && resp_err;
    prdata_d  = '0;
    if (respond && !resp_wr && !resp_err) begin
      prdata_d = rd_data;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      PREADY  <= pready_d;
      PSLVERR <= pslverr_d;
      PRDATA  <= prdata_d;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt     <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (setup_hit) begin
      cnt     <= APB_WAIT_W'(WAIT_STATES);
      idx_q   <= addr_idx;
      wr_q    <= PWRITE;
      err_q   <= addr_err;
      wdata_q <= PWDATA;
      strb_q  <= PSTRB;
    end else if (state == ACCESS) begin
      if (!PSEL) begin
        cnt <= '0;
      end else if (cnt != '0) begin
        cnt <= cnt - APB_WAIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - scoreboard bench for apb_slave_mem (2 and 0 wait states)

module tb_apb_slave_mem;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          err;
  } exp_t;

  logic        clk = 1'b0;
  logic [1:0]  rst, psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr  [2];
  logic [31:0] pwdata [2];
  logic [31:0] prdata [2];
  logic [3:0]  pstrb  [2];

  logic [31:0] model_mem [2][256];
  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  int          acc_cnt [2];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  apb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) dut_ws2 (
    .PCLK(clk), .PRESET(rst[0]), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
    .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0])
  );

  apb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut_ws0 (
    .PCLK(clk), .PRESET(rst[1]), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
    .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1])
  );

  function automatic int ws(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_model(input int u);
    for (int i = 0; i < 256; i++) model_mem[u][i] = '0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the oldest expectation on every completion cycle.
  task automatic mon(input int u);
    exp_t e;
    bit   empty;
    if (rst[u]) begin
      acc_cnt[u] = 0;
      return;
    end
    if (psel[u] && penable[u]) acc_cnt[u]++;
    if (pready[u]) begin
      if (!(psel[u] && penable[u])) begin
        chk("pready_outside_access", 32'(pready[u]), 32'd0);
      end else begin
        empty = (u == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
        if (empty) begin
          chk("unexpected_completion", 32'(pready[u]), 32'd0);
        end else begin
          e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk($sformatf("latency_u%0d", u), 32'(acc_cnt[u]), 32'(ws(u) + 1));
          chk($sformatf("pslverr_u%0d", u), 32'(pslverr[u]), 32'(e.err));
          if (e.rd) chk($sformatf("prdata_u%0d", u), prdata[u], e.data);
        end
      end
      acc_cnt[u] = 0;
    end else begin
      chk($sformatf("quiet_outputs_u%0d", u), {prdata[u][31:1], prdata[u][0] | pslverr[u]}, 32'd0);
      if (!psel[u]) acc_cnt[u] = 0;
    end
  endtask

  always @(negedge clk) mon(0);
  always @(negedge clk) mon(1);

  task automatic push_exp(input int u, input exp_t e);
    if (u == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic xfer(input int u, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb);
    exp_t e;
    int   n;
    int   w;
    e.rd   = !wr;
    e.err  = (addr >> 2) >= 256;
    w      = int'(addr[9:2]);
    e.data = e.err ? 32'd0 : model_mem[u][w];
    if (wr && !e.err) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_mem[u][w][8*b +: 8] = data[8*b +: 8];
    end
    push_exp(u, e);
    psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = wr;
    paddr[u] = addr; pwdata[u] = data; pstrb[u] = strb;
    step();
    penable[u] = 1'b1;
    n = 0;
    while (!pready[u] && n < 40) begin
      step();
      n++;
    end
    if (!pready[u]) begin
      checks++;
      errors++;
      $display("FAIL timeout_u%0d actual=no_pready required=pready", u);
    end
    step();
    psel[u] = 1'b0; penable[u] = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h400 + ($urandom_range(0, 255) << 2);
    if (r == 1) return $urandom;
    return ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 2'b11; psel = '0; penable = '0; pwrite = '0;
    for (int u = 0; u < 2; u++) begin
      paddr[u] = '0; pwdata[u] = '0; pstrb[u] = '0;
      clear_model(u);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 2'b00;
    for (int u = 0; u < 2; u++) begin
      chk("reset_pready", 32'(pready[u]), 32'd0);
      chk("reset_prdata", prdata[u], 32'd0);
      chk("reset_pslverr", 32'(pslverr[u]), 32'd0);
    end

    // Directed, two wait states.
    xfer(0, 0, 32'h10, 32'h0, 4'hF);
    xfer(0, 1, 32'h20, 32'hDEADBEEF, 4'b1111);
    xfer(0, 1, 32'h20, 32'h11223344, 4'b0101);
    xfer(0, 0, 32'h20, 32'h0, 4'h0);
    chk("strobe_model", model_mem[0][8], 32'hDE22BE44);
    xfer(0, 1, 32'h400, 32'hCAFEF00D, 4'hF);
    xfer(0, 1, 32'h3FC, 32'h89ABCDEF, 4'hF);
    xfer(0, 0, 32'h3FC, 32'h0, 4'h0);
    xfer(0, 0, 32'h400, 32'h0, 4'h0);

    // Reset during the second wait cycle of a write.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 32'h8; pwdata[0] = 32'hA5A5A5A5; pstrb[0] = 4'hF;
    step();
    penable[0] = 1'b1;
    step();
    rst[0] = 1'b1;
    #1;
    chk("midreset_pready", 32'(pready[0]), 32'd0);
    chk("midreset_prdata", prdata[0], 32'd0);
    chk("midreset_pslverr", 32'(pslverr[0]), 32'd0);
    psel[0] = 1'b0; penable[0] = 1'b0;
    clear_model(0);
    step();
    rst[0] = 1'b0;
    xfer(0, 0, 32'h8, 32'h0, 4'h0);
    xfer(0, 0, 32'h20, 32'h0, 4'h0);
    xfer(0, 1, 32'h8, 32'h01020304, 4'hF);
    xfer(0, 0, 32'h8, 32'h0, 4'h0);

    // PSEL dropped during the access wait of a write to 0xC.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 32'hC; pwdata[0] = 32'h12345678; pstrb[0] = 4'hF;
    step();
    penable[0] = 1'b1;
    step();
    psel[0] = 1'b0; penable[0] = 1'b0;
    repeat (4) step();
    chk("abort_no_pready", 32'(pready[0]), 32'd0);
    xfer(0, 0, 32'hC, 32'h0, 4'h0);

    // Access phase without a setup phase is ignored.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h14;
    repeat (4) step();
    chk("no_setup_pready", 32'(pready[0]), 32'd0);
    psel[0] = 1'b0; penable[0] = 1'b0;
    step();
    xfer(0, 0, 32'h14, 32'h0, 4'h0);

    // Zero wait states, back to back.
    xfer(1, 1, 32'h0, 32'h5, 4'hF);
    xfer(1, 0, 32'h0, 32'h0, 4'h0);
    xfer(1, 0, 32'h400, 32'h0, 4'h0);
    // Asynchronous reset while PREADY is high.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 32'h0;
    step();
    penable[1] = 1'b1;
    chk("pre_reset_pready", 32'(pready[1]), 32'd1);
    chk("pre_reset_prdata", prdata[1], 32'h5);
    rst[1] = 1'b1;
    #1;
    chk("async_reset_pready", 32'(pready[1]), 32'd0);
    chk("async_reset_prdata", prdata[1], 32'd0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    clear_model(1);
    step();
    rst[1] = 1'b0;
    xfer(1, 0, 32'h0, 32'h0, 4'h0);

    // Randomized traffic on both units.
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 80; i++) begin
        xfer(u, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)));
        repeat ($urandom_range(0, 2)) step();
      end
    end

    repeat (3) step();
    chk("queue0_drained", 32'(exp_q0.size()), 32'd0);
    chk("queue1_drained", 32'(exp_q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
